// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Configuration macro: DIV_EARLY_EXIT_EN (see seq_restoring_divider.sv).
package div_pkg;

  // Default operand width; the dividend is twice this wide.
  localparam int DIV_W = 16;

  // Iteration counter width for the default operand width.
  localparam int DIV_CNT_W = $clog2(DIV_W);

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits. The incoming remainder is always below the divisor
// for a valid operation, so the result fits back into W bits.
module div_step import div_pkg::*; #(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] p_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] p_o,
  output logic         q_o
);

  logic [W:0] shifted;

  // Trial subtraction: keep the difference when the divisor fits, else restore.
  always_comb begin
    shifted = {p_i, bit_i};
    q_o     = (shifted >= {1'b0, divisor_i});
    p_o     = shifted[W-1:0];
    if (q_o) begin
      p_o = W'(shifted - {1'b0, divisor_i});
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: 2W-bit dividend / W-bit divisor.
// One operation in flight, valid/ready handshake on both sides.
// Configuration macro: DIV_EARLY_EXIT_EN -- when defined, overflow and
// divide-by-zero operations skip the iterations and complete after one
// cycle; otherwise they run the full W iterations like any other operation.
module seq_restoring_divider import div_pkg::*; #(
  parameter int W = DIV_W
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           ovf,
  output logic           dbz
);

  localparam int CNT_W = $clog2(W);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     p_q, p_d;
  logic [W-1:0]     lo_q, lo_d;
  logic [W-1:0]     div_q, div_d;
  logic [W-1:0]     quot_q, quot_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;

  logic [W-1:0]     stepP;
  logic             stepQ;
  logic             accDbz;
  logic             accOvf;

  // The low dividend register doubles as the quotient shift register:
  // dividend bits leave at the top while quotient bits enter at the bottom.
  div_step #(.W(W)) uStep (
    .p_i      (p_q),
    .bit_i    (lo_q[W-1]),
    .divisor_i(div_q),
    .p_o      (stepP),
    .q_o      (stepQ)
  );

  // Overflow is known up front: the quotient cannot fit when the high half
  // of the dividend already reaches the divisor.
  always_comb begin
    accDbz = (divisor == '0);
    accOvf = accDbz || (dividend[2*W-1:W] >= divisor);
  end

  // Next-state logic for the controller, datapath and result registers.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    lo_d    = lo_q;
    div_d   = div_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          div_d   = divisor;
          p_d     = dividend[2*W-1:W];
          lo_d    = dividend[W-1:0];
          count_d = '0;
          dbz_d   = accDbz;
          ovf_d   = accOvf;
          quot_d  = '1;
          rem_d   = dividend[W-1:0];
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef DIV_EARLY_EXIT_EN
        if (ovf_q) begin
          state_d = DONE;
        end else begin
`else
        begin
`endif
          p_d     = stepP;
          lo_d    = {lo_q[W-2:0], stepQ};
          count_d = count_q + 1'b1;
          if (count_q == CNT_W'(W - 1)) begin
            state_d = DONE;
            if (!ovf_q) begin
              quot_d = {lo_q[W-2:0], stepQ};
              rem_d  = stepP;
            end
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any operation.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      p_q     <= '0;
      lo_q    <= '0;
      div_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake flags decode from state alone; results come straight from registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    quotient  = quot_q;
    remainder = rem_q;
    ovf       = ovf_q;
    dbz       = dbz_q;
  end

endmodule
